// File: rtl/fpnew_hub_mult_pipe.sv
// Pipelined HUB floating-point multiplier for the FPnew MUL slot.
// It holds a trimmed fpnew_pkg with the types this slice needs, so the file
// compiles on its own. It also holds the combinational HUB multiply core and
// an elastic valid/ready pipeline with flush and a sideband tag.
package fpnew_pkg;
  typedef enum logic [2:0] { FP32, FP64, FP16, FP8, FP16ALT } fp_format_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction
endpackage

module fpnew_hub_mult_pipe #(
  parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP16,
  parameter int unsigned WIDTH       = fpnew_pkg::fp_width(FpFormat),
  parameter int unsigned E           = fpnew_pkg::exp_bits(FpFormat),
  parameter int unsigned M           = fpnew_pkg::man_bits(FpFormat),
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned TagWidth    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [2:0][WIDTH-1:0]      operands_i,
  input  fpnew_pkg::operation_e      op_i,
  input  logic                       op_mod_i,
  input  logic [TagWidth-1:0]        tag_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           result_o,
  output fpnew_pkg::status_t         status_o,
  output logic [TagWidth-1:0]        tag_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  localparam int unsigned PW   = 2 * M + 4;           // product of two (M+2)-bit significands
  localparam int unsigned BIAS = (1 << (E - 1)) - 1;
  localparam int unsigned EMAX = (1 << E) - 1;
  localparam logic [E+2:0] BIAS_W = (E + 3)'(BIAS);
  localparam logic [E+2:0] EMAX_W = (E + 3)'(EMAX);

  logic                 sgn;
  logic [E-1:0]         exp_x, exp_y;
  logic [M+1:0]         sig_x, sig_y;
  logic [PW-1:0]        prod;
  logic [E+2:0]         exp_w;
  logic [M-1:0]         man_z;
  logic [WIDTH-1:0]     z;
  logic [WIDTH-1:0]     in_result;
  fpnew_pkg::status_t   in_status;

  // Operand slot 2 and the product bits below the truncation point never reach the result
  logic unused_bits;
  assign unused_bits = ^{operands_i[2], prod[M+1:0]};

  // HUB multiply: both significands carry an implicit leading 1 and an implicit
  // trailing 1 (the half-ulp bias). Round-to-nearest is then plain truncation.
  // There are no subnormals, so a zero exponent field means zero. Underflow
  // flushes to signed zero. Overflow saturates to the all-ones magnitude.
  always_comb begin
    exp_x = operands_i[0][WIDTH-2 -: E];
    exp_y = operands_i[1][WIDTH-2 -: E];
    sig_x = {1'b1, operands_i[0][M-1:0], 1'b1};
    sig_y = {1'b1, operands_i[1][M-1:0], 1'b1};
    sgn   = operands_i[0][WIDTH-1] ^ operands_i[1][WIDTH-1] ^ op_mod_i;
    prod  = PW'(sig_x) * PW'(sig_y);
    exp_w = {3'b000, exp_x} + {3'b000, exp_y} + {{(E + 2){1'b0}}, prod[PW-1]} - BIAS_W;
    man_z = prod[PW-1] ? prod[PW-2 -: M] : prod[PW-3 -: M];
    z     = {sgn, {(WIDTH - 1){1'b0}}};
    if ((exp_x == '0) || (exp_y == '0)) begin
      z = {sgn, {(WIDTH - 1){1'b0}}};
    end else if (exp_w[E+2] || (exp_w == '0)) begin
      z = {sgn, {(WIDTH - 1){1'b0}}};
    end else if (exp_w > EMAX_W) begin
      z = {sgn, {(WIDTH - 1){1'b1}}};
    end else begin
      z = {sgn, exp_w[E-1:0], man_z};
    end
  end

  // Stage-0 payload. An illegal op still travels down the pipe, but it returns X with only NV set.
  always_comb begin
    in_result = z;
    in_status = '0;
    if (op_i != fpnew_pkg::MUL) begin
      in_result    = operands_i[0];
      in_status.NV = 1'b1;
    end else begin
      in_status.OF = &z[WIDTH-2:0];
      in_status.UF = ~|z[WIDTH-2:0];
    end
  end

  if (NumPipeRegs == 0) begin : g_passthru
    assign result_o    = in_result;
    assign status_o    = in_status;
    assign tag_o       = tag_i;
    assign out_valid_o = in_valid_i & ~flush_i;
    assign in_ready_o  = out_ready_i & ~flush_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic [NumPipeRegs:0] vld_vec;   // index 0 is the input port
    logic [NumPipeRegs:0] rdy;       // rdy[i]: the consumer of stage i's data can take it
    logic [WIDTH-1:0]     stage_res [0:NumPipeRegs];
    fpnew_pkg::status_t   stage_st  [0:NumPipeRegs];
    logic [TagWidth-1:0]  stage_tag [0:NumPipeRegs];

    assign vld_vec[0]   = in_valid_i & ~flush_i;
    assign stage_res[0] = in_result;
    assign stage_st[0]  = in_status;
    assign stage_tag[0] = tag_i;

    // Ready ripples back from the output so bubbles collapse in a single cycle
    always_comb begin
      rdy = '0;
      rdy[NumPipeRegs] = out_ready_i;
      for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
        rdy[i] = ~vld_vec[i+1] | rdy[i+1];
      end
    end

    for (genvar gi = 1; gi <= NumPipeRegs; gi++) begin : g_stage
      logic                load;
      logic                valid_d, valid_q;
      logic [WIDTH-1:0]    result_q;
      fpnew_pkg::status_t  status_q;
      logic [TagWidth-1:0] tag_q;

      assign load = vld_vec[gi-1] & rdy[gi-1];

      // Next-state valid: flush kills, load fills, a downstream take empties
      always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
          valid_d = 1'b0;
        end else if (load) begin
          valid_d = 1'b1;
        end else if (rdy[gi]) begin
          valid_d = 1'b0;
        end
      end

      // Valid flag register
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= valid_d;
        end
      end

      // Payload registers, written only when the stage loads so stalled outputs stay stable
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          result_q <= '0;
          status_q <= '0;
          tag_q    <= '0;
        end else if (load) begin
          result_q <= stage_res[gi-1];
          status_q <= stage_st[gi-1];
          tag_q    <= stage_tag[gi-1];
        end
      end

      assign vld_vec[gi]   = valid_q;
      assign stage_res[gi] = result_q;
      assign stage_st[gi]  = status_q;
      assign stage_tag[gi] = tag_q;
    end

    assign in_ready_o  = rdy[0] & ~flush_i;
    assign out_valid_o = vld_vec[NumPipeRegs];
    assign result_o    = stage_res[NumPipeRegs];
    assign status_o    = stage_st[NumPipeRegs];
    assign tag_o       = stage_tag[NumPipeRegs];
    assign busy_o      = |vld_vec[NumPipeRegs:1];
  end

endmodule

// File: tb/tb_fpnew_hub_mult_pipe.sv
// Testbench for fpnew_hub_mult_pipe. The FP16 instance is built with two pipe
// stages and the FP32 instance is a combinational pass-through. A
// real-arithmetic HUB reference model feeds an in-order scoreboard.
module tb_fpnew_hub_mult_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // FP16, two stages
  logic [2:0][15:0]      ops16;
  fpnew_pkg::operation_e op16;
  logic                  mod16, in_valid16, in_ready16, flush16;
  logic [3:0]            tag16_i, tag16_o;
  logic [15:0]           result16;
  fpnew_pkg::status_t    status16;
  logic                  out_valid16, out_ready16, busy16;
  logic [4:0]            st16;
  assign st16 = status16;

  // FP32, pass-through
  logic [2:0][31:0]      ops32;
  fpnew_pkg::operation_e op32;
  logic                  mod32, in_valid32, in_ready32, flush32;
  logic [3:0]            tag32_i, tag32_o;
  logic [31:0]           result32;
  fpnew_pkg::status_t    status32;
  logic                  out_valid32, out_ready32, busy32;
  logic [4:0]            st32;
  assign st32 = status32;

  fpnew_hub_mult_pipe #(.FpFormat(fpnew_pkg::FP16), .NumPipeRegs(2), .TagWidth(4)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops16), .op_i(op16), .op_mod_i(mod16),
    .tag_i(tag16_i), .in_valid_i(in_valid16), .in_ready_o(in_ready16), .flush_i(flush16),
    .result_o(result16), .status_o(status16), .tag_o(tag16_o), .out_valid_o(out_valid16),
    .out_ready_i(out_ready16), .busy_o(busy16)
  );

  fpnew_hub_mult_pipe #(.FpFormat(fpnew_pkg::FP32), .NumPipeRegs(0), .TagWidth(4)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(ops32), .op_i(op32), .op_mod_i(mod32),
    .tag_i(tag32_i), .in_valid_i(in_valid32), .in_ready_o(in_ready32), .flush_i(flush32),
    .result_o(result32), .status_o(status32), .tag_o(tag32_o), .out_valid_o(out_valid32),
    .out_ready_i(out_ready32), .busy_o(busy32)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_out = 0;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  st;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, obs, expv);
    end
  endtask

  // HUB value of a field triple is (-1)^s * 2^(e-bias) * (1 + (m + 1/2)/2^M).
  // Multiply exactly in real arithmetic, normalise to [1,2), and truncate to M bits.
  function automatic logic [31:0] hub_mul_model(input logic [31:0] x, input logic [31:0] y,
                                                input int eb, input int mb, input logic neg);
    longint unsigned emask, mmask, xe, ye, xm, ym, sg, man, r;
    int  w, bias, e;
    real scale, fx, fy, p;
    w     = 1 + eb + mb;
    bias  = (1 << (eb - 1)) - 1;
    emask = (64'd1 << eb) - 1;
    mmask = (64'd1 << mb) - 1;
    xe    = (64'(x) >> mb) & emask;
    ye    = (64'(y) >> mb) & emask;
    xm    = 64'(x) & mmask;
    ym    = 64'(y) & mmask;
    sg    = ((64'(x) >> (w - 1)) ^ (64'(y) >> (w - 1)) ^ 64'(neg)) & 64'd1;
    r     = sg << (w - 1);
    if (xe != 0 && ye != 0) begin
      scale = real'(64'd1 << mb);
      fx = 1.0 + (real'(xm) + 0.5) / scale;
      fy = 1.0 + (real'(ym) + 0.5) / scale;
      p  = fx * fy;
      e  = int'(xe) + int'(ye) - bias;
      if (p >= 2.0) begin
        p = p / 2.0;
        e = e + 1;
      end
      if (e > int'(emask)) begin
        r = r | ((64'd1 << (w - 1)) - 1);
      end else if (e > 0) begin
        man = longint'($floor((p - 1.0) * scale));
        r = r | (64'(e) << mb) | man;
      end
    end
    return r[31:0];
  endfunction

  function automatic logic [4:0] stat_model(input logic [31:0] r, input int w);
    longint unsigned mask, mag;
    mask = (64'd1 << (w - 1)) - 1;
    mag  = 64'(r) & mask;
    return {1'b0, 1'b0, mag == mask, mag == 0, 1'b0};
  endfunction

  function automatic exp_t expect16(input logic [15:0] x, input logic [15:0] y,
                                    input logic md, input fpnew_pkg::operation_e o, input logic [3:0] t);
    exp_t e;
    logic [31:0] r;
    e.tag = t;
    if (o != fpnew_pkg::MUL) begin
      e.res = x;
      e.st  = 5'b10000;
    end else begin
      r = hub_mul_model({16'h0, x}, {16'h0, y}, 5, 10, md);
      e.res = r[15:0];
      e.st  = stat_model(r, 16);
    end
    return e;
  endfunction

  // Scoreboard, sampled mid-cycle: handshakes seen here complete at the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid16 && out_ready16) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 64'(out_valid16), 64'd0);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          $display("[%0t] out tag=%0d result=%h status=%b (want %h %b)",
                   $time, tag16_o, result16, st16, e.res, e.st);
          check("sb_result", 64'(result16), 64'(e.res));
          check("sb_status", 64'(st16), 64'(e.st));
          check("sb_tag", 64'(tag16_o), 64'(e.tag));
        end
      end
      if (flush16) begin
        exp_q.delete();
      end else if (in_valid16 && in_ready16) begin
        exp_q.push_back(expect16(ops16[0], ops16[1], mod16, op16, tag16_i));
      end
    end
  end

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [3:0] t,
                       input logic md, input fpnew_pkg::operation_e o);
    ops16[0] = x;
    ops16[1] = y;
    ops16[2] = 16'($urandom);
    tag16_i  = t;
    mod16    = md;
    op16     = o;
    in_valid16 = 1'b1;
  endtask

  // Hold the offered operation until it is taken (bounded), then drop valid just after the edge
  task automatic wait_accept(output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready16 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("accept", 64'(in_ready16), 64'd1);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
  endtask

  // Wait (bounded) for the next valid output and capture it; lat counts extra cycles
  task automatic get_out(output logic [15:0] r, output logic [4:0] s, output logic [3:0] t,
                         output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_seen", 64'(out_valid16), 64'd1);
    r = result16;
    s = st16;
    t = tag16_o;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, xr, yr;
    logic [4:0]  s;
    logic [3:0]  t;
    logic [31:0] m32;
    int          w, lat, out_before;
    exp_t        ea;

    rst_n = 1'b0;
    ops16 = '0; op16 = fpnew_pkg::MUL; mod16 = 1'b0; tag16_i = '0;
    in_valid16 = 1'b0; flush16 = 1'b0; out_ready16 = 1'b1;
    ops32 = '0; op32 = fpnew_pkg::MUL; mod32 = 1'b0; tag32_i = '0;
    in_valid32 = 1'b0; flush32 = 1'b0; out_ready32 = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid16), 64'd0);
    check("rst_result", 64'(result16), 64'd0);
    check("rst_status", 64'(st16), 64'd0);
    check("rst_tag", 64'(tag16_o), 64'd0);
    check("rst_busy", 64'(busy16), 64'd0);
    check("rst_in_ready", 64'(in_ready16), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero times one: two-cycle latency, UF set
    drive(16'h0000, 16'h3C00, 4'd5, 1'b0, fpnew_pkg::MUL);
    wait_accept(w);
    get_out(r, s, t, lat);
    check("zero_latency", 64'(lat + 1), 64'd2);
    check("zero_result", 64'(r), 64'h0000);
    check("zero_uf", 64'(s[1]), 64'd1);
    check("zero_of", 64'(s[2]), 64'd0);
    check("zero_tag", 64'(t), 64'd5);

    // Back-to-back random stream: every offer taken at once, outputs in order
    out_before = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(16'($urandom), 16'($urandom), 4'(i), 1'($urandom_range(0, 1)), fpnew_pkg::MUL);
      wait_accept(w);
      check("stream_no_stall", 64'(w), 64'd0);
    end
    repeat (4) tick();
    check("stream_count", 64'(n_out - out_before), 64'd8);

    // Back-pressure: two accepted, third refused, head output stable
    out_ready16 = 1'b0;
    xr = 16'($urandom); yr = 16'($urandom);
    ea = expect16(xr, yr, 1'b0, fpnew_pkg::MUL, 4'd10);
    drive(xr, yr, 4'd10, 1'b0, fpnew_pkg::MUL);
    wait_accept(w);
    drive(16'($urandom), 16'($urandom), 4'd11, 1'b0, fpnew_pkg::MUL);
    wait_accept(w);
    drive(16'($urandom), 16'($urandom), 4'd12, 1'b0, fpnew_pkg::MUL);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready16), 64'd0);
      check("stall_busy", 64'(busy16), 64'd1);
      check("stall_out_valid", 64'(out_valid16), 64'd1);
      check("stall_result", 64'(result16), 64'(ea.res));
      check("stall_tag", 64'(tag16_o), 64'(ea.tag));
    end
    @(posedge clk);
    #1;
    out_ready16 = 1'b1;
    wait_accept(w);
    repeat (5) tick();
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Negated product
    drive(16'h3C00, 16'h3C00, 4'd3, 1'b1, fpnew_pkg::MUL);
    wait_accept(w);
    get_out(r, s, t, lat);
    m32 = hub_mul_model(32'h3C00, 32'h3C00, 5, 10, 1'b0);
    check("neg_result", 64'(r), 64'(m32[15:0] ^ 16'h8000));

    // Illegal op passes X through with NV
    drive(16'h1234, 16'($urandom), 4'd7, 1'b0, fpnew_pkg::ADD);
    wait_accept(w);
    get_out(r, s, t, lat);
    check("illegal_result", 64'(r), 64'h1234);
    check("illegal_status", 64'(s), 64'b10000);

    // Flush a full pipe
    out_ready16 = 1'b0;
    drive(16'($urandom), 16'($urandom), 4'd1, 1'b0, fpnew_pkg::MUL);
    wait_accept(w);
    drive(16'($urandom), 16'($urandom), 4'd2, 1'b0, fpnew_pkg::MUL);
    wait_accept(w);
    flush16 = 1'b1;
    in_valid16 = 1'b1;
    @(negedge clk);
    check("flush_busy_before", 64'(busy16), 64'd1);
    check("flush_in_ready", 64'(in_ready16), 64'd0);
    tick();
    flush16 = 1'b0;
    in_valid16 = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy16), 64'd0);
    check("flush_out_valid", 64'(out_valid16), 64'd0);
    tick();
    out_ready16 = 1'b1;

    // Asynchronous reset mid-stream
    out_ready16 = 1'b0;
    drive(16'h3C00, 16'h4000, 4'd9, 1'b0, fpnew_pkg::MUL);
    wait_accept(w);
    drive(16'($urandom), 16'($urandom), 4'd8, 1'b0, fpnew_pkg::MUL);
    wait_accept(w);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", 64'(out_valid16), 64'd0);
    check("arst_result", 64'(result16), 64'd0);
    check("arst_status", 64'(st16), 64'd0);
    check("arst_tag", 64'(tag16_o), 64'd0);
    check("arst_busy", 64'(busy16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_no_output", 64'(out_valid16), 64'd0);
    end

    // FP32 pass-through build
    ops32[0] = 32'h7FFFFFFF; ops32[1] = 32'h7FFFFFFF; ops32[2] = 32'($urandom);
    tag32_i = 4'd6; in_valid32 = 1'b1; out_ready32 = 1'b1;
    #1;
    m32 = hub_mul_model(32'h7FFFFFFF, 32'h7FFFFFFF, 8, 23, 1'b0);
    check("fp32_sat_result", 64'(result32), 64'(m32));
    check("fp32_of", 64'(st32[2]), 64'(&result32[30:0]));
    check("fp32_status", 64'(st32), 64'(stat_model(m32, 32)));
    check("fp32_out_valid", 64'(out_valid32), 64'd1);
    check("fp32_tag", 64'(tag32_o), 64'd6);
    check("fp32_busy", 64'(busy32), 64'd0);
    ops32[0] = 32'h3F800000; ops32[1] = 32'h40400000;
    #1;
    m32 = hub_mul_model(32'h3F800000, 32'h40400000, 8, 23, 1'b0);
    check("fp32_result", 64'(result32), 64'(m32));
    out_ready32 = 1'b0;
    #1;
    check("fp32_in_ready_stall", 64'(in_ready32), 64'd0);
    out_ready32 = 1'b1;
    flush32 = 1'b1;
    #1;
    check("fp32_flush_valid", 64'(out_valid32), 64'd0);
    check("fp32_flush_ready", 64'(in_ready32), 64'd0);
    flush32 = 1'b0;

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
